// File: rtl/ahblite_user_regbank.sv
// AHB-Lite slave exposing NUM_REGS 32-bit registers with write/set/clear/toggle ops and byte lanes.
// Define AHBLITE_USER_REGBANK_ERR_RESP_EN for two-cycle ERROR responses on illegal accesses.
module ahblite_user_regbank #(
  parameter int unsigned NUM_REGS = 4,
  parameter logic [31:0] REG0_RST = 32'hFFFFFFFF
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     HSEL,
  input  logic [1:0]               HTRANS,
  input  logic [2:0]               HSIZE,
  input  logic [3:0]               HPROT,
  input  logic                     HWRITE,
  input  logic [31:0]              HADDR,
  input  logic [31:0]              HWDATA,
  input  logic                     HREADY,
  output logic                     HREADYOUT,
  output logic                     HRESP,
  output logic [31:0]              HRDATA,
  output logic [NUM_REGS*32-1:0]   REG_OUT,
  output logic [NUM_REGS-1:0]      REG_WSTB
);

`ifdef AHBLITE_USER_REGBANK_ERR_RESP_EN
  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;
`else
  typedef enum logic [0:0] {IDLE, DATA} state_t;
`endif

  state_t              state_q, state_d;
  logic [7:0]          addr_q, addr_d;
  logic [2:0]          size_q, size_d;
  logic                write_q, write_d;
  logic                legal_q, legal_d;
  logic [31:0]         regs_q [NUM_REGS];
  logic [31:0]         regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wstb_q, wstb_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                hreadyout_q, hreadyout_d;
  logic                hresp_q, hresp_d;
  logic                accept, capture, addr_ok;
  logic                unused_inputs;

  assign unused_inputs = ^{HPROT, HTRANS[0], HADDR[31:8]};

  function automatic logic legal_access(input logic [7:0] addr, input logic [2:0] size);
    logic ok;
    ok = 1'b1;
    if (32'(addr[5:2]) >= NUM_REGS)           ok = 1'b0;
    if (size > 3'd2)                          ok = 1'b0;
    if (size == 3'd1 && addr[0])              ok = 1'b0;
    if (size == 3'd2 && addr[1:0] != 2'b00)   ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] addr, input logic [2:0] size);
    logic [3:0] m;
    case (size)
      3'd0:    m = 4'b0001 << addr;
      3'd1:    m = addr[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] apply_op(input logic [31:0] cur, input logic [31:0] wdata,
                                           input logic [1:0] op, input logic [3:0] lanes);
    logic [31:0] res;
    case (op)
      2'b00:   res = wdata;
      2'b01:   res = cur | wdata;
      2'b10:   res = cur & ~wdata;
      default: res = cur ^ wdata;
    endcase
    for (int unsigned b = 0; b < 4; b++) begin
      if (!lanes[b]) res[8*b +: 8] = cur[8*b +: 8];
    end
    return res;
  endfunction

  always_comb begin
    accept  = HSEL & HTRANS[1] & HREADY;
    addr_ok = legal_access(HADDR[7:0], HSIZE);
    capture = accept && (state_q == IDLE || state_q == DATA);

    state_d = IDLE;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    legal_d = legal_q;
    regs_d  = regs_q;
    wstb_d  = '0;
    rdata_d = '0;

    case (state_q)
      IDLE, DATA: begin
        if (accept) begin
`ifdef AHBLITE_USER_REGBANK_ERR_RESP_EN
          state_d = addr_ok ? DATA : ERR1;
`else
          state_d = DATA;
`endif
        end
      end
`ifdef AHBLITE_USER_REGBANK_ERR_RESP_EN
      ERR1:    state_d = ERR2;
      ERR2:    state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

    if (capture) begin
      addr_d  = HADDR[7:0];
      size_d  = HSIZE;
      write_d = HWRITE;
      legal_d = addr_ok;
    end

    if (state_q == DATA && write_q && legal_q) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (32'(addr_q[5:2]) == i) begin
          regs_d[i] = apply_op(regs_q[i], HWDATA, addr_q[7:6], lane_mask(addr_q[1:0], size_q));
          wstb_d[i] = 1'b1;
        end
      end
    end

    // Read data is taken from the next-state register image so a read right after a write sees it.
    if (capture && !HWRITE && addr_ok) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (32'(HADDR[5:2]) == i) rdata_d = regs_d[i];
      end
    end

`ifdef AHBLITE_USER_REGBANK_ERR_RESP_EN
    hreadyout_d = (state_d != ERR1);
    hresp_d     = (state_d == ERR1) || (state_d == ERR2);
`else
    hreadyout_d = 1'b1;
    hresp_d     = 1'b0;
`endif
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
      legal_q     <= 1'b0;
      wstb_q      <= '0;
      rdata_q     <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == 0) ? REG0_RST : '0;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      write_q     <= write_d;
      legal_q     <= legal_d;
      wstb_q      <= wstb_d;
      rdata_q     <= rdata_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      regs_q      <= regs_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      REG_OUT[32*i +: 32] = regs_q[i];
    end
  end

  assign REG_WSTB  = wstb_q;
  assign HRDATA    = rdata_q;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahblite_user_regbank.sv
// Self-checking bench for ahblite_user_regbank; read data expectations go through a scoreboard queue.
module tb_ahblite_user_regbank;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic         HSEL;
  logic [1:0]   HTRANS;
  logic [2:0]   HSIZE;
  logic [3:0]   HPROT;
  logic         HWRITE;
  logic [31:0]  HADDR;
  logic [31:0]  HWDATA;
  logic         HREADY;
  logic         HREADYOUT;
  logic         HRESP;
  logic [31:0]  HRDATA;
  logic [127:0] REG_OUT;
  logic [3:0]   REG_WSTB;

  int checks = 0;
  int errors = 0;
  int wstb_cnt [4];
  logic [31:0] pend_wdata = '0;
  logic [31:0] exp_q [$];

  ahblite_user_regbank #(.NUM_REGS(4), .REG0_RST(32'hFFFFFFFF)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HPROT(HPROT), .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .REG_OUT(REG_OUT), .REG_WSTB(REG_WSTB)
  );

  always #5 HCLK = ~HCLK;

  initial for (int i = 0; i < 4; i++) wstb_cnt[i] = 0;

  always @(negedge HCLK) begin
    for (int i = 0; i < 4; i++) if (REG_WSTB[i] === 1'b1) wstb_cnt[i]++;
  end

  // One address phase per call; HWDATA carries the previous phase's data.
  task automatic step(input logic sel, input logic [1:0] trans, input logic rdy, input logic wr,
                      input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    HSEL = sel; HTRANS = trans; HREADY = rdy; HWRITE = wr; HADDR = addr; HSIZE = size;
    HWDATA = pend_wdata;
    pend_wdata = wdata;
    @(posedge HCLK); #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    step(1'b1, 2'b10, 1'b1, 1'b1, addr, size, data);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] expv);
    exp_q.push_back(expv);
    step(1'b1, 2'b10, 1'b1, 1'b0, addr, 3'd2, 32'h0);
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 1'b1, 1'b0, 32'h0, 3'd0, 32'h0);
  endtask

  task automatic check_regs(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (REG_OUT[32*i +: 32] !== e[i]) begin
        errors++;
        $display("FAIL %s reg%0d got %h expected %h", tag, i, REG_OUT[32*i +: 32], e[i]);
      end
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; HPROT = 4'h3;
    HSEL = 0; HTRANS = 0; HSIZE = 0; HWRITE = 0; HADDR = 0; HWDATA = 0; HREADY = 1;
    repeat (3) @(posedge HCLK);
    #1;
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0 || REG_WSTB !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b resp=%b rdata=%h wstb=%b expected 1 0 0 0",
               HREADYOUT, HRESP, HRDATA, REG_WSTB);
    end
    check_regs("in_reset", 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);
    HRESETn = 1'b1;
    idle();
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b resp=%b expected 1 0", HREADYOUT, HRESP);
    end
    check_regs("after_reset", 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_write_set_read();
    int c1;
    logic [31:0] expv;
    c1 = wstb_cnt[1];
    wr(32'h04, 3'd2, 32'h12345678);
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
      errors++;
      $display("FAIL write_okay got rdy=%b resp=%b expected 1 0", HREADYOUT, HRESP);
    end
    wr(32'h44, 3'd2, 32'h000000F0);
    rd(32'h04, 32'h123456F8);
    checks++;
    expv = exp_q.pop_front();
    if (HRDATA !== expv) begin
      errors++;
      $display("FAIL set_read got %h expected %h", HRDATA, expv);
    end
    idle();
    checks++;
    if (HRDATA !== 32'h0) begin
      errors++;
      $display("FAIL rdata_idle got %h expected 00000000", HRDATA);
    end
    checks++;
    if (wstb_cnt[1] - c1 != 2) begin
      errors++;
      $display("FAIL wstb1_pulses got %0d expected 2", wstb_cnt[1] - c1);
    end
  endtask

  task automatic test_byte_toggle();
    wr(32'h0A, 3'd0, 32'h00AB0000);
    wr(32'hC8, 3'd2, 32'hFFFFFFFF);
    idle();
    idle();
    check_regs("byte_toggle", 32'hFFFFFFFF, 32'h123456F8, 32'hFF54FFFF, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] expv;
    wr(32'h0C, 3'd2, 32'hCAFEF00D);
    rd(32'h0C, 32'hCAFEF00D);
    checks++;
    expv = exp_q.pop_front();
    if (HRDATA !== expv || HREADYOUT !== 1'b1) begin
      errors++;
      $display("FAIL b2b_read got %h rdy=%b expected %h rdy=1", HRDATA, HREADYOUT, expv);
    end
    // halfword clear of the upper lanes, then read via an address carrying the set op field
    wr(32'h8E, 3'd1, 32'hFFFF0000);
    rd(32'h4C, 32'h0000F00D);
    checks++;
    expv = exp_q.pop_front();
    if (HRDATA !== expv) begin
      errors++;
      $display("FAIL half_clear_read got %h expected %h", HRDATA, expv);
    end
    idle();
  endtask

  task automatic test_illegal();
    int tot;
    logic [31:0] expv;
    tot = wstb_cnt[0] + wstb_cnt[1] + wstb_cnt[2] + wstb_cnt[3];
    wr(32'h10, 3'd2, 32'hDEADBEEF);
`ifdef AHBLITE_USER_REGBANK_ERR_RESP_EN
    checks++;
    if (HREADYOUT !== 1'b0 || HRESP !== 1'b1) begin
      errors++;
      $display("FAIL err1 got rdy=%b resp=%b expected 0 1", HREADYOUT, HRESP);
    end
    step(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b1) begin
      errors++;
      $display("FAIL err2 got rdy=%b resp=%b expected 1 1", HREADYOUT, HRESP);
    end
    idle();
`else
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
      errors++;
      $display("FAIL illegal_okay got rdy=%b resp=%b expected 1 0", HREADYOUT, HRESP);
    end
    rd(32'h10, 32'h0);
    checks++;
    expv = exp_q.pop_front();
    if (HRDATA !== expv) begin
      errors++;
      $display("FAIL illegal_read got %h expected %h", HRDATA, expv);
    end
    wr(32'h01, 3'd1, 32'h00000000);
`endif
    idle();
    idle();
    checks++;
    if (HRESP !== 1'b0 || HREADYOUT !== 1'b1) begin
      errors++;
      $display("FAIL illegal_after got rdy=%b resp=%b expected 1 0", HREADYOUT, HRESP);
    end
    check_regs("illegal", 32'hFFFFFFFF, 32'h123456F8, 32'hFF54FFFF, 32'h0000F00D);
    checks++;
    if (wstb_cnt[0] + wstb_cnt[1] + wstb_cnt[2] + wstb_cnt[3] != tot) begin
      errors++;
      $display("FAIL illegal_wstb got %0d pulses expected 0",
               wstb_cnt[0] + wstb_cnt[1] + wstb_cnt[2] + wstb_cnt[3] - tot);
    end
  endtask

  task automatic test_no_capture();
    int c0;
    c0 = wstb_cnt[0];
    step(1'b0, 2'b10, 1'b1, 1'b1, 32'h00, 3'd2, 32'h0);
    step(1'b1, 2'b01, 1'b1, 1'b1, 32'h00, 3'd2, 32'h0);
    step(1'b1, 2'b10, 1'b0, 1'b1, 32'h00, 3'd2, 32'h0);
    idle();
    idle();
    check_regs("no_capture", 32'hFFFFFFFF, 32'h123456F8, 32'hFF54FFFF, 32'h0000F00D);
    checks++;
    if (wstb_cnt[0] != c0) begin
      errors++;
      $display("FAIL no_capture_wstb got %0d pulses expected 0", wstb_cnt[0] - c0);
    end
  endtask

  task automatic test_reset_abort();
    int c0;
    wr(32'h00, 3'd2, 32'h55555555);
    c0 = wstb_cnt[0];
    HWDATA = pend_wdata; HSEL = 0; HTRANS = 2'b00;
    HRESETn = 1'b0;
    pend_wdata = '0;
    @(posedge HCLK); #1;
    checks++;
    if (REG_WSTB !== 4'h0 || HRDATA !== 32'h0 || HREADYOUT !== 1'b1) begin
      errors++;
      $display("FAIL abort_outputs got wstb=%b rdata=%h rdy=%b expected 0 0 1",
               REG_WSTB, HRDATA, HREADYOUT);
    end
    HRESETn = 1'b1;
    idle();
    idle();
    check_regs("reset_abort", 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);
    checks++;
    if (wstb_cnt[0] != c0) begin
      errors++;
      $display("FAIL abort_wstb got %0d pulses expected 0", wstb_cnt[0] - c0);
    end
  endtask

  initial begin
    test_reset();
    test_write_set_read();
    test_byte_toggle();
    test_back_to_back();
    test_illegal();
    test_no_capture();
    test_reset_abort();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
